// File: rtl/gbe_stats_pkg.sv
// Shared types and defaults for the gbe TX/RX statistics blocks.
// Optional build macro used by gbe_stats_ctr: GBE_TX_STATS_SAT_EN.
package gbe_stats_pkg;

  localparam int GBE_CTR_WIDTH       = 32;
  localparam int GBE_MAX_FRAME_WORDS = 1125;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_OVERSIZE = 2'd2
  } tx_frm_state_t;

endpackage

// File: rtl/gbe_stats_ctr.sv
// Generic event counter for the gbe stats blocks; synchronous clear wins over increment.
// Macro GBE_TX_STATS_SAT_EN: saturate at all-ones instead of wrapping.
module gbe_stats_ctr #(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CTR_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc) begin
`ifdef GBE_TX_STATS_SAT_EN
      if (cnt != {CTR_WIDTH{1'b1}})
        cnt <= cnt + CTR_WIDTH'(1);
`else
      cnt <= cnt + CTR_WIDTH'(1);
`endif
    end
  end

endmodule

// File: rtl/gbe_tx_stats_ctr.sv
// Per-port TX statistics: valid words, good/oversize frames, overflow edges, last frame length.
// Macro GBE_TX_STATS_SAT_EN selects saturating counters (see gbe_stats_ctr).
module gbe_tx_stats_ctr
  import gbe_stats_pkg::*;
#(
  parameter int CTR_WIDTH       = GBE_CTR_WIDTH,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_FRAME_WORDS = GBE_MAX_FRAME_WORDS
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 ctr_clr,
  input  logic                 tx_valid,
  input  logic                 tx_end_of_frame,
  input  logic                 tx_overflow,
  output logic [CTR_WIDTH-1:0] txvldctr,
  output logic [CTR_WIDTH-1:0] txeofctr,
  output logic [CTR_WIDTH-1:0] txerrctr,
  output logic [CTR_WIDTH-1:0] txofctr,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_active
);

  // One extra bit so len+1 at the limit can be compared without wrapping.
  localparam logic [LEN_WIDTH:0] MAX_W = (LEN_WIDTH+1)'(MAX_FRAME_WORDS);

  tx_frm_state_t        state, state_nxt;
  logic [LEN_WIDTH-1:0] len, len_nxt;
  logic [LEN_WIDTH:0]   len_inc;
  logic                 oversz, eof_inc, err_inc, of_hist, of_inc;

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    eof_inc   = 1'b0;
    err_inc   = 1'b0;
    len_inc   = {1'b0, len} + (LEN_WIDTH+1)'(1);
    oversz    = (len_inc > MAX_W);
    if (tx_valid) begin
      case (state)
        ST_IDLE:
          if (tx_end_of_frame) eof_inc = 1'b1;
          else begin
            len_nxt   = LEN_WIDTH'(1);
            state_nxt = ST_IN_FRAME;
          end
        ST_IN_FRAME:
          if (oversz) begin
            err_inc   = 1'b1;
            state_nxt = ST_OVERSIZE;
          end else if (tx_end_of_frame) begin
            eof_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end else
            len_nxt = len_inc[LEN_WIDTH-1:0];
        ST_OVERSIZE:
          if (tx_end_of_frame) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM and len ignore ctr_clr so a frame spanning a clear still completes.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      frame_active <= 1'b0;
      of_hist      <= 1'b0;
    end else begin
      state        <= state_nxt;
      len          <= len_nxt;
      frame_active <= (state_nxt != ST_IDLE);
      of_hist      <= tx_overflow;
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst)
      frame_len <= '0;
    else if (ctr_clr)
      frame_len <= '0;
    else if (eof_inc)
      frame_len <= (state == ST_IDLE) ? LEN_WIDTH'(1) : len_inc[LEN_WIDTH-1:0];
  end

  assign of_inc = tx_overflow & ~of_hist;

  gbe_stats_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_vld_ctr (
    .clk(user_clk), .rst(user_rst), .clr(ctr_clr), .inc(tx_valid), .cnt(txvldctr));
  gbe_stats_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_eof_ctr (
    .clk(user_clk), .rst(user_rst), .clr(ctr_clr), .inc(eof_inc), .cnt(txeofctr));
  gbe_stats_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_err_ctr (
    .clk(user_clk), .rst(user_rst), .clr(ctr_clr), .inc(err_inc), .cnt(txerrctr));
  gbe_stats_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_of_ctr (
    .clk(user_clk), .rst(user_rst), .clr(ctr_clr), .inc(of_inc), .cnt(txofctr));

endmodule

// File: tb/tb_gbe_tx_stats_ctr.sv
// Directed bench for gbe_tx_stats_ctr: default build plus a MAX_FRAME_WORDS=8 instance.
module tb_gbe_tx_stats_ctr;

  logic user_clk = 1'b0;
  logic user_rst, ctr_clr, tx_valid, tx_end_of_frame, tx_overflow;

  logic [31:0] vld, eof, err, ofc;
  logic [15:0] flen;
  logic        act;
  logic [31:0] vld8, eof8, err8, ofc8;
  logic [15:0] flen8;
  logic        act8;

  int checks = 0;
  int failures = 0;

  always #5 user_clk = ~user_clk;

  gbe_tx_stats_ctr dut (
    .user_clk(user_clk), .user_rst(user_rst), .ctr_clr(ctr_clr), .tx_valid(tx_valid),
    .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow),
    .txvldctr(vld), .txeofctr(eof), .txerrctr(err), .txofctr(ofc),
    .frame_len(flen), .frame_active(act));

  gbe_tx_stats_ctr #(.MAX_FRAME_WORDS(8)) dut8 (
    .user_clk(user_clk), .user_rst(user_rst), .ctr_clr(ctr_clr), .tx_valid(tx_valid),
    .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow),
    .txvldctr(vld8), .txeofctr(eof8), .txerrctr(err8), .txofctr(ofc8),
    .frame_len(flen8), .frame_active(act8));

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic cyc(input logic v, input logic e);
    tx_valid = v;
    tx_end_of_frame = e;
    @(negedge user_clk);
    tx_valid = 1'b0;
    tx_end_of_frame = 1'b0;
  endtask

  task automatic frame(input int n);
    for (int i = 1; i <= n; i++) cyc(1'b1, i == n);
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    repeat (2) @(negedge user_clk);
    user_rst = 1'b0;
    @(negedge user_clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (vld !== 32'd0) begin failures++; $display("FAIL reset_vld got=%0h exp=0", vld); end
    if (eof !== 32'd0) begin failures++; $display("FAIL reset_eof got=%0h exp=0", eof); end
    if (err !== 32'd0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
    if (ofc !== 32'd0) begin failures++; $display("FAIL reset_of got=%0h exp=0", ofc); end
    if (flen !== 16'd0) begin failures++; $display("FAIL reset_len got=%0h exp=0", flen); end
    if (act !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", act); end
  endtask

  task automatic test_frames();
    do_reset();
    frame(4);
    frame(4);
    cyc(1'b1, 1'b0);
    checks += 1;
    if (act !== 1'b1) begin failures++; $display("FAIL frames_active_mid got=%0b exp=1", act); end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    checks += 5;
    if (vld !== 32'd12) begin failures++; $display("FAIL frames_vld got=%0d exp=12", vld); end
    if (eof !== 32'd3) begin failures++; $display("FAIL frames_eof got=%0d exp=3", eof); end
    if (flen !== 16'd4) begin failures++; $display("FAIL frames_len got=%0d exp=4", flen); end
    if (err !== 32'd0) begin failures++; $display("FAIL frames_err got=%0d exp=0", err); end
    if (act !== 1'b0) begin failures++; $display("FAIL frames_active_end got=%0b exp=0", act); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    checks += 2;
    if (flen !== 16'd1) begin failures++; $display("FAIL b2b_len1 got=%0d exp=1", flen); end
    if (eof !== 32'd1) begin failures++; $display("FAIL b2b_eof1 got=%0d exp=1", eof); end
    cyc(1'b1, 1'b1);
    checks += 3;
    if (eof !== 32'd2) begin failures++; $display("FAIL b2b_eof got=%0d exp=2", eof); end
    if (flen !== 16'd2) begin failures++; $display("FAIL b2b_len got=%0d exp=2", flen); end
    if (vld !== 32'd3) begin failures++; $display("FAIL b2b_vld got=%0d exp=3", vld); end
  endtask

  task automatic test_oversize();
    do_reset();
    frame(10);
    frame(5);
    checks += 5;
    if (err8 !== 32'd1) begin failures++; $display("FAIL ovs_err got=%0d exp=1", err8); end
    if (eof8 !== 32'd1) begin failures++; $display("FAIL ovs_eof got=%0d exp=1", eof8); end
    if (flen8 !== 16'd5) begin failures++; $display("FAIL ovs_len got=%0d exp=5", flen8); end
    if (vld8 !== 32'd15) begin failures++; $display("FAIL ovs_vld got=%0d exp=15", vld8); end
    if (eof !== 32'd2) begin failures++; $display("FAIL ovs_big_eof got=%0d exp=2", eof); end
    // exactly at the limit is good; one past with EOF on that word is oversize
    frame(8);
    checks += 2;
    if (eof8 !== 32'd2) begin failures++; $display("FAIL ovs_max_eof got=%0d exp=2", eof8); end
    if (flen8 !== 16'd8) begin failures++; $display("FAIL ovs_max_len got=%0d exp=8", flen8); end
    frame(9);
    checks += 4;
    if (err8 !== 32'd2) begin failures++; $display("FAIL ovs_9_err got=%0d exp=2", err8); end
    if (eof8 !== 32'd2) begin failures++; $display("FAIL ovs_9_eof got=%0d exp=2", eof8); end
    if (flen8 !== 16'd8) begin failures++; $display("FAIL ovs_9_len got=%0d exp=8", flen8); end
    if (act8 !== 1'b1) begin failures++; $display("FAIL ovs_9_active got=%0b exp=1", act8); end
    cyc(1'b1, 1'b1);
    checks += 2;
    if (act8 !== 1'b0) begin failures++; $display("FAIL ovs_exit_active got=%0b exp=0", act8); end
    if (eof8 !== 32'd2) begin failures++; $display("FAIL ovs_exit_eof got=%0d exp=2", eof8); end
  endtask

  task automatic test_eof_no_valid();
    do_reset();
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    checks += 2;
    if (eof !== 32'd0) begin failures++; $display("FAIL noval_eof got=%0d exp=0", eof); end
    if (act !== 1'b1) begin failures++; $display("FAIL noval_active got=%0b exp=1", act); end
    cyc(1'b1, 1'b1);
    checks += 1;
    if (flen !== 16'd2) begin failures++; $display("FAIL noval_len got=%0d exp=2", flen); end
  endtask

  task automatic test_overflow();
    tx_overflow = 1'b1;
    do_reset();
    @(negedge user_clk);
    checks += 1;
    if (ofc !== 32'd1) begin failures++; $display("FAIL of_rst_hold got=%0d exp=1", ofc); end
    tx_overflow = 1'b0;
    @(negedge user_clk);
    for (int p = 0; p < 2; p++) begin
      tx_overflow = 1'b1;
      repeat (3) @(negedge user_clk);
      tx_overflow = 1'b0;
      repeat (2) @(negedge user_clk);
    end
    checks += 1;
    if (ofc !== 32'd3) begin failures++; $display("FAIL of_count got=%0d exp=3", ofc); end
  endtask

  task automatic test_clear();
    do_reset();
    frame(3);
    cyc(1'b1, 1'b0);
    ctr_clr = 1'b1;
    cyc(1'b1, 1'b1);
    checks += 3;
    if (vld !== 32'd0) begin failures++; $display("FAIL clr_vld got=%0d exp=0", vld); end
    if (eof !== 32'd0) begin failures++; $display("FAIL clr_eof got=%0d exp=0", eof); end
    if (flen !== 16'd0) begin failures++; $display("FAIL clr_len got=%0d exp=0", flen); end
    ctr_clr = 1'b0;
    frame(2);
    checks += 2;
    if (eof !== 32'd1) begin failures++; $display("FAIL clr_after_eof got=%0d exp=1", eof); end
    if (vld !== 32'd2) begin failures++; $display("FAIL clr_after_vld got=%0d exp=2", vld); end
    // frame straddling a clear still completes with its full length
    cyc(1'b1, 1'b0);
    ctr_clr = 1'b1;
    cyc(1'b1, 1'b0);
    ctr_clr = 1'b0;
    cyc(1'b1, 1'b1);
    checks += 3;
    if (eof !== 32'd1) begin failures++; $display("FAIL clr_span_eof got=%0d exp=1", eof); end
    if (flen !== 16'd3) begin failures++; $display("FAIL clr_span_len got=%0d exp=3", flen); end
    if (vld !== 32'd1) begin failures++; $display("FAIL clr_span_vld got=%0d exp=1", vld); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_end;
`ifdef GBE_TX_STATS_SAT_EN
    exp_end = 32'hFFFF_FFFF;
`else
    exp_end = 32'h0000_0001;
`endif
    do_reset();
    force dut.u_vld_ctr.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_vld_ctr.cnt;
    @(negedge user_clk);
    cyc(1'b1, 1'b0);
    checks += 1;
    if (vld !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_top got=%0h exp=ffffffff", vld); end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks += 1;
    if (vld !== exp_end) begin failures++; $display("FAIL wrap_end got=%0h exp=%0h", vld, exp_end); end
  endtask

  initial begin
    user_rst = 1'b1;
    ctr_clr = 1'b0;
    tx_valid = 1'b0;
    tx_end_of_frame = 1'b0;
    tx_overflow = 1'b0;
    @(negedge user_clk);
    test_reset();
    test_frames();
    test_back_to_back();
    test_oversize();
    test_eof_no_valid();
    test_overflow();
    test_clear();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gbe_tx_stats_ctr.md
# gbe_tx_stats_ctr

Per-port transmit statistics engine for the 10GbE core, placed between the user-side TX interface of a `gbe` port and its software-readable status registers. It observes the TX handshake in the `user_clk` domain and maintains four counters: valid words, completed frames, oversize frames and overflow events. It also reports the length of the last completed frame. Each counter output drives the `user_data_in` bus of an `opb_register_simulink2ppc` slave, for example `gbe1_txvldctr`.

## Interface
- `CTR_WIDTH`, 32, width of every event counter; must match the register bus width.
- `LEN_WIDTH`, 16, width of the frame-length counter and of `frame_len`.
- `MAX_FRAME_WORDS`, 1125, largest legal frame in 64-bit words (9000 B jumbo); range 1 to 2^LEN_WIDTH−1.

Ports:
- `user_clk`  in  1  sole clock.
- `user_rst`  in  1  reset, asynchronous, active-high.
- `ctr_clr`  in  1  software clear, level-sensitive, synchronous.
- `tx_valid`  in  1  TX word strobe.
- `tx_end_of_frame`  in  1  last word of frame; meaningful only with `tx_valid`.
- `tx_overflow`  in  1  TX FIFO overflow flag from the core.
- `txvldctr`  out  CTR_WIDTH  count of valid words.
- `txeofctr`  out  CTR_WIDTH  count of good frames.
- `txerrctr`  out  CTR_WIDTH  count of oversize frames.
- `txofctr`  out  CTR_WIDTH  count of `tx_overflow` rising edges.
- `frame_len`  out  LEN_WIDTH  word count of the last good frame.
- `frame_active`  out  1  high while the FSM is in `IN_FRAME` or `OVERSIZE`.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to `IDLE`.
- `txvldctr`
  - Increments on every cycle with `tx_valid`=1, in all FSM states.
- FSM states: `IDLE`, `IN_FRAME`, `OVERSIZE`. Internal `len` counter is LEN_WIDTH bits.
- From `IDLE`:
  - `tx_valid` & `tx_end_of_frame` → single-word frame: `txeofctr`+1, `frame_len`←1, stay in `IDLE`.
  - `tx_valid` & !`tx_end_of_frame` → `len`←1, go to `IN_FRAME`.
- From `IN_FRAME`, on `tx_valid`:
  - If `len`+1 > MAX_FRAME_WORDS → `txerrctr`+1, go to `OVERSIZE`. This check takes priority over `tx_end_of_frame`.
  - Else if `tx_end_of_frame` → `txeofctr`+1, `frame_len`←`len`+1, go to `IDLE`.
  - Else `len`←`len`+1.
- From `OVERSIZE`:
  - `tx_valid` & `tx_end_of_frame` → go to `IDLE`; `txeofctr` and `frame_len` are unchanged.
- `tx_end_of_frame` without `tx_valid` is ignored in every state.
- `txofctr`
  - Increments on a 0→1 transition of `tx_overflow`, sampled via a one-flop history register.
  - The history flop resets to 0, so overflow held high out of reset counts once.
- `ctr_clr`=1:
  - Holds all four counters and `frame_len` at 0; clear wins over a same-cycle event.
  - The FSM and `len` continue operating, so a frame in progress is still counted if it completes after the clear is released.
- `user_rst` asserted mid-frame: all state is lost immediately; the partial frame is never counted.

## Timing
- Counter latency: the event at edge N is visible on the output after edge N (1 cycle).
- Clear latency: an output reads 0 in the cycle after the first edge that samples `ctr_clr`=1.
- Back-to-back frames (EOF followed by valid on the next cycle) are fully supported. Frames are counted at one per cycle maximum, with no bubbles required.
- Wrap-around (macro off): counters wrap from 2^CTR_WIDTH−1 to 0.
- `len` cannot wrap, because `OVERSIZE` is entered before overflow.

## Configuration
- `GBE_TX_STATS_SAT_EN`
  - Defined: all four counters saturate at 2^CTR_WIDTH−1 and hold until `ctr_clr` or reset.
  - Undefined: counters wrap modulo 2^CTR_WIDTH.
- `frame_len` behaviour is identical in both builds.

## Structure
- Shared package `gbe_stats_pkg`:
  - FSM state enum `tx_frm_state_t`.
  - Default constants `GBE_CTR_WIDTH`=32 and `GBE_MAX_FRAME_WORDS`=1125.
- Sub-module `gbe_stats_ctr`:
  - One instance per counter.
  - Ports: clock, reset, clear, increment; parameter CTR_WIDTH.
  - Contains the saturate/wrap selection.
  - The same sub-module is reused by the future RX stats block.

## Test plan
- Reset, then send 3 frames of 4 words each → `txvldctr`=12, `txeofctr`=3, `frame_len`=4, `txerrctr`=0, `frame_active`=0.
- Single-word frame in `IDLE`, then an immediate back-to-back 2-word frame → `txeofctr`=2, `frame_len`=2.
- With MAX_FRAME_WORDS=8, send a 10-word frame then a 5-word frame → `txerrctr`=1, `txeofctr`=1, `frame_len`=5, `txvldctr`=15.
- Pulse `tx_overflow` high for 3 cycles, twice; also hold it high through reset release → `txofctr`=3.
- Assert `ctr_clr` in the same cycle as a valid EOF → all counters read 0 next cycle. Release it, then complete a 2-word frame → `txeofctr`=1.
- Preload counter to 2^32−2 (force), then send 3 words → 0x00000001 without the macro, 0xFFFFFFFF with `GBE_TX_STATS_SAT_EN`.
